// File: rtl/mips_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_loader_pkg
//  Description : Shared definitions for the host-side program/data loader:
//                header op codes, header field positions, FSM state encoding
//                and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_loader_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RUN_W  = 26;

  // Header op codes, header bits [31:30]
  localparam logic [1:0] OP_LOAD_I   = 2'b00;
  localparam logic [1:0] OP_LOAD_D   = 2'b01;
  localparam logic [1:0] OP_RUN      = 2'b10;
  localparam logic [1:0] OP_READBACK = 2'b11;

  // Header field positions
  localparam int HDR_OP_MSB   = 31;
  localparam int HDR_OP_LSB   = 30;
  localparam int HDR_CNT_MSB  = 25;
  localparam int HDR_CNT_LSB  = 16;
  localparam int HDR_BUD_MSB  = 25;

  // Word-count field width (holds N-1)
  localparam int CNT_W = HDR_CNT_MSB - HDR_CNT_LSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_I  = 3'd1,
    ST_LOAD_D  = 3'd2,
    ST_RUN     = 3'd3,
    ST_RB_ADDR = 3'd4,
    ST_RB_SEND = 3'd5,
    ST_STATUS  = 3'd6
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/mips_host_loader_out_slot.sv
`default_nettype none
// ============================================================================
//  Module      : loader_out_slot
//  Description : Single-entry output holding register with valid/ready.
//                A loaded word is held unchanged until the host accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_out_slot
  import mips_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  // Capture a result word on load; drop valid once the host takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_host_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mips_host_loader
//  Description : Host-side controller for the core memory-load interface.
//                Decodes a 32-bit header/word stream, writes instruction and
//                data memories, releases the core for a cycle budget while
//                counting taken-branch pulses, and streams data-memory words
//                and status back to the host.
//  Options     : LOADER_CHECKSUM_EN - emit XOR checksum word after each load.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_host_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RUN_W  = DEF_RUN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              ins_we,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] data_addr,
  output logic              data_we,
  output logic              proc_rst,
  input  logic [DATA_W-1:0] proc_out,
  input  logic              proc_done,
  output logic              busy
);

  loader_state_t state, state_nxt;

  logic              xfer;
  logic              out_fire;
  logic [1:0]        hdr_op;
  logic [CNT_W-1:0]  hdr_cnt;
  logic [ADDR_W-1:0] hdr_base;
  logic [RUN_W-1:0]  hdr_budget;

  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic              last_word;
  logic [RUN_W-1:0]  run_left;
  logic [RUN_W-1:0]  count;
  logic [RUN_W-1:0]  count_nxt;

  logic              slot_load;
  logic [DATA_W-1:0] slot_data;

  // Host words are only taken while idle or loading, and never in reset.
  assign in_ready = rst && (state == ST_IDLE || state == ST_LOAD_I || state == ST_LOAD_D);
  assign xfer     = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign busy     = (state != ST_IDLE);

  assign hdr_op     = in_data[HDR_OP_MSB:HDR_OP_LSB];
  assign hdr_cnt    = in_data[HDR_CNT_MSB:HDR_CNT_LSB];
  assign hdr_base   = in_data[ADDR_W-1:0];
  assign hdr_budget = RUN_W'(in_data[HDR_BUD_MSB:0]);

  assign last_word  = (remaining == '0);

  // Taken-branch count including the current cycle, saturating at all-ones.
  assign count_nxt = (proc_done && (count != {RUN_W{1'b1}})) ? count + RUN_W'(1) : count;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  // Running XOR of the payload words of the current load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum <= '0;
    end else if (state == ST_IDLE && xfer) begin
      csum <= '0;
    end else if ((state == ST_LOAD_I || state == ST_LOAD_D) && xfer) begin
      csum <= csum ^ in_data;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and result-slot loading.
  always_comb begin
    state_nxt = state;
    slot_load = 1'b0;
    slot_data = '0;
    case (state)
      ST_IDLE: begin
        if (xfer) begin
          case (hdr_op)
            OP_LOAD_I: state_nxt = ST_LOAD_I;
            OP_LOAD_D: state_nxt = ST_LOAD_D;
            OP_RUN: begin
              if (hdr_budget == '0) begin
                // Zero budget: report an empty count without releasing.
                state_nxt = ST_STATUS;
                slot_load = 1'b1;
              end else begin
                state_nxt = ST_RUN;
              end
            end
            default: state_nxt = ST_RB_ADDR;
          endcase
        end
      end
      ST_LOAD_I, ST_LOAD_D: begin
        if (xfer && last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = ST_STATUS;
          slot_load = 1'b1;
          slot_data = csum ^ in_data;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
      ST_RUN: begin
        if (run_left == '0) begin
          state_nxt = ST_STATUS;
          slot_load = 1'b1;
          slot_data = DATA_W'(count_nxt);
        end
      end
      ST_RB_ADDR: begin
        // data_addr has been stable this cycle; take the memory word.
        state_nxt = ST_RB_SEND;
        slot_load = 1'b1;
        slot_data = proc_out;
      end
      ST_RB_SEND: begin
        if (out_fire) begin
          state_nxt = last_word ? ST_IDLE : ST_RB_ADDR;
        end
      end
      ST_STATUS: begin
        if (out_fire) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Memory write ports, core reset, address and budget counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr      <= '0;
      instr_addr <= '0;
      ins_we     <= 1'b0;
      data       <= '0;
      data_addr  <= '0;
      data_we    <= 1'b0;
      proc_rst   <= 1'b1;
      addr       <= '0;
      remaining  <= '0;
      run_left   <= '0;
      count      <= '0;
    end else begin
      ins_we  <= 1'b0;
      data_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            addr      <= hdr_base;
            remaining <= hdr_cnt;
            if (hdr_op == OP_READBACK) begin
              data_addr <= hdr_base;
            end
            if (hdr_op == OP_RUN && hdr_budget != '0) begin
              proc_rst <= 1'b0;
              run_left <= hdr_budget - RUN_W'(1);
              count    <= '0;
            end
          end
        end
        ST_LOAD_I: begin
          if (xfer) begin
            instr      <= in_data;
            instr_addr <= addr;
            ins_we     <= 1'b1;
            addr       <= addr + ADDR_W'(1);
            remaining  <= remaining - CNT_W'(1);
          end
        end
        ST_LOAD_D: begin
          if (xfer) begin
            data      <= in_data;
            data_addr <= addr;
            data_we   <= 1'b1;
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - CNT_W'(1);
          end
        end
        ST_RUN: begin
          count <= count_nxt;
          if (run_left == '0) begin
            proc_rst <= 1'b1;
          end else begin
            run_left <= run_left - RUN_W'(1);
          end
        end
        ST_RB_SEND: begin
          if (out_fire) begin
            addr      <= addr + ADDR_W'(1);
            data_addr <= addr + ADDR_W'(1);
            remaining <= remaining - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  loader_out_slot #(
    .DATA_W (DATA_W)
  ) u_out_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (slot_load),
    .load_data (slot_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

endmodule
`default_nettype wire
